// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
// - ALU_OP_* : 3-bit opcode encodings. All eight codes are legal.
// - SEL_W    : width of the one-hot unit select (bit index = opcode).
// - SHAMT_W  : shift-amount width used by the 32-bit logical right shifter.
// - alu_req_t: one buffered request {op, a, b, tag}.
package alu_pkg;

  localparam int ALU_DW  = 32;
  localparam int SEL_W   = 8;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 4;

  localparam logic [2:0] ALU_OP_AND = 3'd0;
  localparam logic [2:0] ALU_OP_OR  = 3'd1;
  localparam logic [2:0] ALU_OP_ADD = 3'd2;
  localparam logic [2:0] ALU_OP_XOR = 3'd3;
  localparam logic [2:0] ALU_OP_NOR = 3'd4;
  localparam logic [2:0] ALU_OP_SRL = 3'd5;
  localparam logic [2:0] ALU_OP_SUB = 3'd6;
  localparam logic [2:0] ALU_OP_SLT = 3'd7;

  typedef struct packed {
    logic [2:0]        op;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic [TAG_W-1:0]  tag;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry valid/ready skid buffer carrying alu_req_t.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o : upstream handshake; in_ready_o is registered
//   in_data_i             : request to store on a push
//   out_valid_o/out_ready_i: downstream handshake; out_valid_o = (count != 0)
//   out_data_o            : entry at the read pointer (unmasked; stale when empty)
module alu_issue_skid
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  alu_req_t in_data_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output alu_req_t out_data_o
);

  logic     wp_q, rp_q;
  logic [1:0] count_q, count_d;
  logic     in_ready_q;
  logic     push, pop;
  alu_req_t mem_q [DEPTH];

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_o & out_ready_i;

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;  // idle, or push+pop: occupancy unchanged
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
      count_q    <= count_d;
      // Registered ready looks at next occupancy, so upstream never sees a
      // combinational path from out_ready.
      in_ready_q <= (count_d < 2'(DEPTH));
    end
  end

  // NOTE: entry storage is deliberately not reset; the occupancy count is
  // reset, and the top masks outputs while empty, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data_i;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rp_q];

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the ALU datapath.
// Buffers up to two {op, a, b} requests, tags each with a 4-bit sequence
// number, and decodes the head entry into a one-hot unit select and the
// shifter's 5-bit shift amount.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake (in_ready registered)
//   in_op, in_a, in_b    : opcode and operands
//   out_valid/out_ready  : handshake to the ALU
//   out_a, out_b         : operands, unchanged
//   out_shamt            : in_b[4:0] for SRL, else 0
//   out_sel              : one-hot, bit index = opcode
//   out_tag              : request sequence number, wraps 15->0
// All out_* data are forced to 0 while out_valid is low.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW    = 32,  // only 32 supported: shifter is fixed width
  parameter int DEPTH = 2    // fixed: skid pointers are 1 bit
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [DW-1:0]      in_a,
  input  logic [DW-1:0]      in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_a,
  output logic [DW-1:0]      out_b,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [SEL_W-1:0]   out_sel,
  output logic [TAG_W-1:0]   out_tag
);

  logic [TAG_W-1:0] tag_q, tag_d;
  alu_req_t         in_req, out_req;

  assign in_req = '{op: in_op, a: in_a, b: in_b, tag: tag_q};

  // Tag advances only on an accepted push, so it names the request it rides with.
  assign tag_d = (in_valid & in_ready) ? tag_q + 4'd1 : tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  alu_issue_skid #(.DEPTH(DEPTH)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_req),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_req)
  );

  // Decode from the head entry; everything masked to 0 when empty.
  always_comb begin
    out_a     = '0;
    out_b     = '0;
    out_shamt = '0;
    out_sel   = '0;
    out_tag   = '0;
    if (out_valid) begin
      out_a   = out_req.a;
      out_b   = out_req.b;
      out_sel = SEL_W'(1) << out_req.op;
      out_tag = out_req.tag;
      if (out_req.op == ALU_OP_SRL) out_shamt = out_req.b[SHAMT_W-1:0];
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small queue model of the stage.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_a, out_b;
  logic [4:0]  out_shamt;
  logic [7:0]  out_sel;
  logic [3:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;

  alu_req_t   mq[$];        // model contents, head = next to pop
  logic [3:0] m_tag;
  logic       m_in_ready;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt),
    .out_sel(out_sel), .out_tag(out_tag)
  );

  // Upstream protocol: a stalled request must be held unchanged.
  logic        pend;
  logic [66:0] pend_data;
  always @(posedge clk) begin
    if (rst_n && pend)
      assert (in_valid && {in_op, in_a, in_b} == pend_data)
        else $error("upstream protocol violation: stalled request changed");
    pend      <= rst_n && in_valid && !in_ready;
    pend_data <= {in_op, in_a, in_b};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_empty_outputs(input string tag);
    check({tag, ".out_a"},     out_a,     0);
    check({tag, ".out_b"},     out_b,     0);
    check({tag, ".out_shamt"}, out_shamt, 0);
    check({tag, ".out_sel"},   out_sel,   0);
    check({tag, ".out_tag"},   out_tag,   0);
  endtask

  task automatic model_clear();
    mq.delete();
    m_tag      = 4'd0;
    m_in_ready = 1'b1;
  endtask

  // Called at posedge+1. Drives one cycle of inputs, checks current outputs
  // against the model, advances the model, then waits to the next posedge+1.
  task automatic drive_cycle(input logic v, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic ordy);
    alu_req_t e;
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy;
    check("out_valid", out_valid, (mq.size() != 0));
    check("in_ready",  in_ready,  m_in_ready);
    if (mq.size() != 0) begin
      e = mq[0];
      check("out_a",     out_a,     e.a);
      check("out_b",     out_b,     e.b);
      check("out_sel",   out_sel,   32'(8'h01 << e.op));
      check("out_shamt", out_shamt, (e.op == 3'd5) ? 32'(e.b[4:0]) : 32'd0);
      check("out_tag",   out_tag,   e.tag);
      if (ordy) void'(mq.pop_front());
    end else begin
      check_empty_outputs("empty");
    end
    if (v && m_in_ready) begin
      mq.push_back('{op: op, a: a, b: b, tag: m_tag});
      m_tag = m_tag + 4'd1;
    end
    m_in_ready = (mq.size() < 2);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; in_op = 0; in_a = 0; in_b = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready",  in_ready,  1);
    check_empty_outputs("rst");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    model_clear();
  endtask

  localparam logic [7:0] SEL_TBL [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                         8'h10, 8'h20, 8'h40, 8'h80};
  localparam logic ORDY_PAT [14] = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1};

  initial begin
    logic [31:0] a_cur, b_cur;
    logic [2:0]  op_cur;
    int          k;

    // Single SRL push
    do_reset();
    drive_cycle(1, ALU_OP_SRL, 32'h8000_0000, 32'h0000_0024, 1);
    check("srl.out_valid", out_valid, 1);
    check("srl.out_shamt", out_shamt, 4);
    check("srl.out_sel",   out_sel,   8'h20);
    check("srl.out_tag",   out_tag,   0);
    drive_cycle(0, 0, 0, 0, 1);
    check("srl.drained",   out_valid, 0);
    drive_cycle(0, 0, 0, 0, 1);

    // Back-pressure
    drive_cycle(1, ALU_OP_ADD, 32'd1, 32'd2, 0);
    drive_cycle(1, ALU_OP_SUB, 32'd5, 32'd3, 0);
    check("bp.in_ready_full", in_ready,  0);
    check("bp.hold_sel",      out_sel,   8'h04);
    check("bp.hold_shamt",    out_shamt, 0);
    check("bp.hold_a",        out_a,     1);
    drive_cycle(0, 0, 0, 0, 0);
    check("bp.still_held",    out_b,     2);
    drive_cycle(0, 0, 0, 0, 1);   // ADD pops
    check("bp.ready_back",    in_ready,  1);
    check("bp.sub_sel",       out_sel,   8'h40);
    drive_cycle(0, 0, 0, 0, 1);   // SUB pops
    drive_cycle(0, 0, 0, 0, 1);

    // Streaming with tag wrap
    do_reset();
    for (int i = 0; i < 20; i++)
      drive_cycle(1, 3'(i), 32'h1000_0000 + 32'(i), 32'(i * 7 + 3), 1);
    check("stream.tag_wrap", out_tag, 3);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);

    // Simultaneous push/pop at count 1 and 2; stalled data held
    k = 0;
    op_cur = 3'(k); a_cur = 32'hA000_0000; b_cur = 32'h0000_0030;
    for (int i = 0; i < 14; i++) begin
      logic acc;
      acc = m_in_ready;
      drive_cycle(1, op_cur, a_cur, b_cur, ORDY_PAT[i]);
      if (acc) begin
        k++;
        op_cur = 3'(k * 3); a_cur = 32'hA000_0000 + 32'(k); b_cur = 32'(k * 5 + 32);
      end
    end
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1);

    // Asynchronous reset mid-operation at count 2
    drive_cycle(1, ALU_OP_XOR, 32'h1, 32'h2, 0);
    drive_cycle(1, ALU_OP_NOR, 32'h3, 32'h4, 0);
    check("mid.full", in_ready, 0);
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    check("mid.out_valid", out_valid, 0);
    check("mid.in_ready",  in_ready,  1);
    check("mid.out_a",     out_a,     0);
    model_clear();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    drive_cycle(1, ALU_OP_OR, 32'h55, 32'h66, 1);
    check("mid.first_tag", out_tag, 0);
    drive_cycle(0, 0, 0, 0, 1);

    // Decode sweep
    for (int op = 0; op < 8; op++) begin
      drive_cycle(1, 3'(op), 32'(op), 32'hFFFF_FFFF, 1);
      check("sweep.sel",   out_sel,   SEL_TBL[op]);
      check("sweep.shamt", out_shamt, (op == 5) ? 31 : 0);
    end
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(1, ALU_OP_SRL, 32'h0, 32'h0000_0025, 1);
    check("shamt_low_bits", out_shamt, 5);
    check("b_full_value",   out_b,     32'h25);
    drive_cycle(0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
